// File: rtl/flash_audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flash_audio_pkg
//  Description : Shared types, widths and sample attenuation helper for the
//                flash-to-codec playback engine.
//  Revision    : 1.0  initial release
// ============================================================================
package flash_audio_pkg;

    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 32;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_WAIT = 2'd2
    } fetch_state_t;

    typedef enum logic [0:0] {
        O_IDLE = 1'b0,
        O_HOLD = 1'b1
    } out_state_t;

    // Floor division by 2^shift, keeping the sign of the PCM sample.
    function automatic logic [SAMPLE_W-1:0] atten(input logic [SAMPLE_W-1:0] sample,
                                                  input logic [3:0]          shift);
        return $signed(sample) >>> shift;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flash_audio_streamer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO; dout shows the
//                oldest entry whenever empty is low.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int                c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is still legal when the same cycle pops.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == c_FULL);

endmodule
`default_nettype wire

// File: rtl/flash_audio_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : flash_audio_streamer
//  Description : Streams packed 16-bit PCM from the flash Avalon-MM read port
//                to the audio codec, with prefetch, attenuation and looping.
//  Revision    : 1.0  initial release
// ============================================================================
module flash_audio_streamer
    import flash_audio_pkg::*;
#(
    parameter int                ADDR_W      = 23,
    parameter logic [ADDR_W-1:0] START_ADDR  = 23'h000000,
    parameter logic [ADDR_W-1:0] END_ADDR    = 23'h0FFFFF,
    parameter int                ATTEN_SHIFT = 6,
    parameter int                STEREO      = 0,
    parameter int                LOOP        = 1,
    parameter int                FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                flash_mem_read,
    input  logic                flash_mem_waitrequest,
    output logic [ADDR_W-1:0]   flash_mem_address,
    input  logic [WORD_W-1:0]   flash_mem_readdata,
    input  logic                flash_mem_readdatavalid,
    input  logic                write_ready,
    output logic                write_s,
    output logic [SAMPLE_W-1:0] writedata_left,
    output logic [SAMPLE_W-1:0] writedata_right,
    output logic                playing,
    output logic                done
);

    localparam int                 c_CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]         c_SHIFT     = 4'(ATTEN_SHIFT);
    localparam bit                 c_STEREO    = (STEREO != 0);
    localparam bit                 c_LOOP      = (LOOP != 0);

    fetch_state_t        r_fstate;
    fetch_state_t        w_fstate_nxt;
    out_state_t          r_ostate;
    out_state_t          w_ostate_nxt;

    logic [ADDR_W-1:0]   r_addr;
    logic                r_fetch_end;
    logic                r_stopped;
    logic                r_half;
    logic                r_write_s;
    logic                r_done;
    logic [SAMPLE_W-1:0] r_left;
    logic [SAMPLE_W-1:0] r_right;

    logic                w_push;
    logic                w_pop;
    logic                w_load;
    logic                w_finish;
    logic                w_start;
    logic                w_room;
    logic [WORD_W-1:0]   w_fifo_dout;
    logic [c_CNT_W-1:0]  w_fifo_count;
    logic [c_CNT_W-1:0]  w_free_slots;
    logic                w_empty;
    logic                w_full;
    logic [SAMPLE_W-1:0] w_samp_lo;
    logic [SAMPLE_W-1:0] w_samp_hi;
    logic [SAMPLE_W-1:0] w_samp_mono;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (flash_mem_readdata),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .empty (w_empty),
        .full  (w_full)
    );

    // The word still in flight is counted as occupied so the FIFO can never overflow.
    assign w_free_slots = c_DEPTH_CNT - w_fifo_count - c_CNT_W'(r_fstate != F_IDLE);
    assign w_room       = !w_full && (w_free_slots != '0);

    always_comb begin
        w_fstate_nxt = r_fstate;
        w_push       = 1'b0;
        case (r_fstate)
            F_IDLE: begin
                if (run && !r_stopped && !r_fetch_end && w_room) begin
                    w_fstate_nxt = F_REQ;
                end
            end
            F_REQ: begin
                if (!flash_mem_waitrequest) begin
                    w_fstate_nxt = F_WAIT;
                end
            end
            F_WAIT: begin
                if (flash_mem_readdatavalid) begin
                    w_push       = 1'b1;
                    w_fstate_nxt = F_IDLE;
                end
            end
            default: w_fstate_nxt = F_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fstate    <= F_IDLE;
            r_addr      <= START_ADDR;
            r_fetch_end <= 1'b0;
        end else begin
            r_fstate <= w_fstate_nxt;
            if (w_push) begin
                if (r_addr == END_ADDR) begin
                    if (c_LOOP) begin
                        r_addr <= START_ADDR;
                    end else begin
                        r_fetch_end <= 1'b1;
                    end
                end else begin
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

    assign w_samp_lo   = atten(w_fifo_dout[SAMPLE_W-1:0], c_SHIFT);
    assign w_samp_hi   = atten(w_fifo_dout[WORD_W-1:SAMPLE_W], c_SHIFT);
    assign w_samp_mono = r_half ? w_samp_hi : w_samp_lo;
    assign w_start     = run && !r_stopped && !w_empty && write_ready;

    always_comb begin
        w_ostate_nxt = r_ostate;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_finish     = 1'b0;
        case (r_ostate)
            O_IDLE: begin
                if (w_start) begin
                    w_load       = 1'b1;
                    w_pop        = c_STEREO || r_half;
                    w_ostate_nxt = O_HOLD;
                end
            end
            O_HOLD: begin
                if (!write_ready) begin
                    w_ostate_nxt = O_IDLE;
                    // Last word fetched and fully drained: the one-shot is over.
                    w_finish     = r_fetch_end && w_empty && !r_stopped;
                end
            end
            default: w_ostate_nxt = O_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ostate  <= O_IDLE;
            r_half    <= 1'b0;
            r_write_s <= 1'b0;
            r_left    <= '0;
            r_right   <= '0;
            r_stopped <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_ostate  <= w_ostate_nxt;
            r_write_s <= w_load;
            r_done    <= w_finish;
            if (w_finish) begin
                r_stopped <= 1'b1;
            end
            if (w_load) begin
                if (c_STEREO) begin
                    r_left  <= w_samp_lo;
                    r_right <= w_samp_hi;
                    r_half  <= 1'b0;
                end else begin
                    r_left  <= w_samp_mono;
                    r_right <= w_samp_mono;
                    r_half  <= ~r_half;
                end
            end
        end
    end

    assign flash_mem_read    = (r_fstate == F_REQ);
    assign flash_mem_address = r_addr;
    assign write_s           = r_write_s;
    assign writedata_left    = r_left;
    assign writedata_right   = r_right;
    assign playing           = run && !r_stopped;
    assign done              = r_done;

endmodule
`default_nettype wire
